// File: rtl/n1_pkg.sv
// Shared definitions for the n1 neuron family: FSM states, byte width,
// default accumulator geometry and the signed byte multiply helper.
package n1_pkg;

  localparam int BYTE_W    = 8;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Full-precision signed 8x8 product; the result always fits in 16 bits.
  function automatic logic signed [15:0] mul8(input logic [BYTE_W-1:0] a,
                                              input logic [BYTE_W-1:0] b);
    logic signed [15:0] a_ext;
    logic signed [15:0] b_ext;
    a_ext = {{8{a[7]}}, a};
    b_ext = {{8{b[7]}}, b};
    return a_ext * b_ext;
  endfunction

endpackage

// File: rtl/n1_sat.sv
// Combinational ACC_W-to-8 saturation.
// Build option N1_RELU_EN: clamp to 0..127 (negatives give 0x00);
// otherwise signed saturation to -128..127.
module n1_sat
  import n1_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0]  din,
  output logic        [BYTE_W-1:0] dout
);

  localparam logic signed [ACC_W-1:0] MAX8 = ACC_W'(32'sd127);
  localparam logic signed [ACC_W-1:0] MIN8 = ACC_W'(-32'sd128);
  localparam logic signed [ACC_W-1:0] ZERO = ACC_W'(32'sd0);

  // Clamp the wide value into the 8-bit result range.
  always_comb begin
    dout = 8'h00;
`ifdef N1_RELU_EN
    if (din < ZERO) begin
      dout = 8'h00;
    end else if (din > MAX8) begin
      dout = 8'h7F;
    end else begin
      dout = din[BYTE_W-1:0];
    end
`else
    if (din > MAX8) begin
      dout = 8'h7F;
    end else if (din < MIN8) begin
      dout = 8'h80;
    end else begin
      dout = din[BYTE_W-1:0];
    end
`endif
  end

endmodule

// File: rtl/n1_neuron.sv
// Sequential single-neuron dot-product engine: bias plus N_INPUTS signed
// (weight, activation) beats, arithmetic right shift, 8-bit saturation.
// Build option N1_RELU_EN selects a ReLU clamp in the saturation stage.
module n1_neuron
  import n1_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SHIFT    = DEF_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_w,
  input  logic [BYTE_W-1:0] in_x,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              out_ack,
  output logic              busy
);

  state_t                    state_r;
  state_t                    state_s;
  logic signed [ACC_W-1:0]   acc_r;
  logic [7:0]                count_r;
  logic [BYTE_W-1:0]         out_data_r;
  logic signed [15:0]        prod_s;
  logic signed [ACC_W-1:0]   prod_ext_s;
  logic signed [ACC_W-1:0]   bias_ext_s;
  logic signed [ACC_W-1:0]   scaled_s;
  logic [BYTE_W-1:0]         sat_s;
  logic                      last_beat_s;

  // Datapath operands: sign-extended product, pre-scaled bias, scaled sum.
  always_comb begin
    prod_s      = mul8(in_w, in_x);
    prod_ext_s  = {{(ACC_W-16){prod_s[15]}}, prod_s};
    bias_ext_s  = {{(ACC_W-BYTE_W){bias[7]}}, bias} <<< SHIFT;
    scaled_s    = acc_r >>> SHIFT;
    last_beat_s = (count_r == 8'(N_INPUTS - 1));
  end

  n1_sat #(.ACC_W(ACC_W)) u_sat (
    .din  (scaled_s),
    .dout (sat_s)
  );

  // Next-state logic; in_ready depends on state only, so a valid beat in ACCUM is accepted.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid && last_beat_s) begin
          state_s = SCALE;
        end else begin
          state_s = ACCUM;
        end
      end
      SCALE: begin
        state_s = OUTPUT;
      end
      OUTPUT: begin
        if (out_ack) begin
          state_s = IDLE;
        end else begin
          state_s = OUTPUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, accumulator, beat counter and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      acc_r      <= '0;
      count_r    <= 8'd0;
      out_data_r <= 8'h00;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r   <= bias_ext_s;
            count_r <= 8'd0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_r   <= acc_r + prod_ext_s;
            count_r <= count_r + 8'd1;
          end
        end
        SCALE: begin
          out_data_r <= sat_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == OUTPUT);
  assign busy      = (state_r != IDLE);
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_n1_neuron.sv
// Scoreboard bench for n1_neuron: instance 0 uses SHIFT=0, instance 1 SHIFT=4,
// both with N_INPUTS=4 and ACC_W=24. Expected results are hand-computed.
module tb_n1_neuron;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       start_v, in_valid_v, out_ack_v;
  logic [1:0][7:0]  bias_v, w_v, x_v;
  logic             ir0, ir1, ov0, ov1, bz0, bz1;
  logic [7:0]       od0, od1;
  logic [1:0]       in_ready_v, out_valid_v, busy_v;
  logic [1:0][7:0]  out_data_v;

  assign in_ready_v  = {ir1, ir0};
  assign out_valid_v = {ov1, ov0};
  assign busy_v      = {bz1, bz0};
  assign out_data_v  = {od1, od0};

  n1_neuron #(.N_INPUTS(4), .ACC_W(24), .SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .bias(bias_v[0]),
    .in_valid(in_valid_v[0]), .in_ready(ir0), .in_w(w_v[0]), .in_x(x_v[0]),
    .out_valid(ov0), .out_data(od0), .out_ack(out_ack_v[0]), .busy(bz0)
  );

  n1_neuron #(.N_INPUTS(4), .ACC_W(24), .SHIFT(4)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .bias(bias_v[1]),
    .in_valid(in_valid_v[1]), .in_ready(ir1), .in_w(w_v[1]), .in_x(x_v[1]),
    .out_valid(ov1), .out_data(od1), .out_ack(out_ack_v[1]), .busy(bz1)
  );

  typedef struct {
    logic [7:0] data;
    int         last;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  logic [1:0] prev_ov = 2'b00;

  // Free-running edge counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: on each rising out_valid pop one expectation and compare.
  // The last beat is accepted at edge A; out_valid is seen after edge A+1,
  // so a consumer sampling on the clock sees it from edge A+2.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (out_valid_v[s] && !prev_ov[s]) begin
        int   sz;
        exp_t e;
        sz = (s == 0) ? exp_q0.size() : exp_q1.size();
        chk($sformatf("sb_avail%0d", s), (sz > 0), 1);
        if (sz > 0) begin
          e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("out_data%0d", s), out_data_v[s], e.data);
          chk($sformatf("latency%0d", s), cyc, e.last + 1);
        end
      end
    end
    prev_ov <= out_valid_v;
  end

  // One evaluation on instance sel; optional random in_valid gaps and delayed ack.
  task automatic run(input int sel, input logic [7:0] b,
                     input logic [3:0][7:0] ws, input logic [3:0][7:0] xs,
                     input bit gaps, input int ack_delay, input logic [7:0] expd);
    int   t;
    exp_t e;
    @(negedge clk);
    start_v[sel] = 1'b1;
    bias_v[sel]  = b;
    @(negedge clk);
    start_v[sel] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      t = 0;
      while (!in_ready_v[sel] && t < 10) begin
        @(negedge clk);
        t++;
      end
      chk("in_ready", in_ready_v[sel], 1);
      in_valid_v[sel] = 1'b1;
      w_v[sel] = ws[i];
      x_v[sel] = xs[i];
      if (i == 3) begin
        e.data = expd;
        e.last = cyc + 1;
        if (sel == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
      end
      @(negedge clk);
      in_valid_v[sel] = 1'b0;
      w_v[sel] = 8'h00;
      x_v[sel] = 8'h00;
    end
    t = 0;
    while (!out_valid_v[sel] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("out_valid", out_valid_v[sel], 1);
    for (int d = 0; d < ack_delay; d++) begin
      chk("hold_valid", out_valid_v[sel], 1);
      chk("hold_data", out_data_v[sel], expd);
      chk("hold_in_ready", in_ready_v[sel], 0);
      chk("hold_busy", busy_v[sel], 1);
      start_v[sel] = d[0];
      @(negedge clk);
    end
    out_ack_v[sel] = 1'b1;
    start_v[sel]   = (ack_delay > 0);
    @(negedge clk);
    out_ack_v[sel] = 1'b0;
    start_v[sel]   = 1'b0;
    chk("idle_valid", out_valid_v[sel], 0);
    chk("idle_busy", busy_v[sel], 0);
    chk("idle_data", out_data_v[sel], expd);
  endtask

  logic [3:0][7:0] w1, x1, wn, xn, ws1, xs1, wm, xm, wz;
  logic [7:0] exp_neg, exp_msat, exp_m1;

  initial begin
    w1  = {8'd7, 8'd5, 8'd3, 8'd1};
    x1  = {8'd8, 8'd6, 8'd4, 8'd2};
    wn  = {8'd0, 8'd0, 8'd0, 8'hFF};
    xn  = {8'd0, 8'd0, 8'd0, 8'd50};
    ws1 = {4{8'd127}};
    xs1 = {4{8'd127}};
    wm  = {4{8'h80}};
    xm  = {4{8'd127}};
    wz  = {4{8'h00}};
`ifdef N1_RELU_EN
    exp_neg  = 8'h00;
    exp_msat = 8'h00;
    exp_m1   = 8'h00;
`else
    exp_neg  = 8'hC4;
    exp_msat = 8'h80;
    exp_m1   = 8'hFF;
`endif
    rst = 1'b1;
    start_v = 2'b00; in_valid_v = 2'b00; out_ack_v = 2'b00;
    bias_v = '0; w_v = '0; x_v = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", out_valid_v[s], 0);
      chk("rst_ready", in_ready_v[s], 0);
      chk("rst_busy", busy_v[s], 0);
      chk("rst_data", out_data_v[s], 0);
    end
    rst = 1'b0;

    run(0, 8'd0,  w1,  x1,  1'b0, 0, 8'h64);    // 2+12+30+56 = 100
    run(0, 8'hF6, wn,  xn,  1'b0, 0, exp_neg);  // -10 - 50 = -60
    run(0, 8'd0,  ws1, xs1, 1'b0, 0, 8'h7F);    // 64516 saturates
    run(0, 8'd0,  wm,  xm,  1'b0, 0, exp_msat); // -65024 saturates
    run(0, 8'd0,  w1,  x1,  1'b1, 0, 8'h64);    // gaps, same result
    run(0, 8'd0,  w1,  x1,  1'b0, 5, 8'h64);    // delayed ack

    // Reset in the middle of an evaluation after two accepted beats.
    @(negedge clk);
    start_v[0] = 1'b1; bias_v[0] = 8'd0;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_v[0] = 1'b1; w_v[0] = w1[i]; x_v[0] = x1[i];
      @(negedge clk);
    end
    in_valid_v[0] = 1'b0;
    chk("mid_busy", busy_v[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid", out_valid_v[0], 0);
    chk("mrst_ready", in_ready_v[0], 0);
    chk("mrst_busy", busy_v[0], 0);
    chk("mrst_data", out_data_v[0], 0);
    run(0, 8'd0, w1, x1, 1'b0, 0, 8'h64);

    run(1, 8'd1,  w1, x1, 1'b0, 0, 8'd7);       // (16+100)>>>4 = 7
    run(1, 8'hFF, wz, wz, 1'b0, 0, exp_m1);     // -16>>>4 = -1

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q0.size() + exp_q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
